// File: rtl/seq_runner_pkg.sv
// Shared definitions for the pattern runner: FSM encoding, default pattern
// length and the "no hit yet" marker used by first_hit.
package seq_runner_pkg;

    localparam int unsigned SEQ_N  = 64;
    localparam logic [6:0]  NO_HIT = 7'h7F;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/seq_runner_shift.sv
// N-bit parallel-load shift register; streams MSB first, zero-filling from the
// bottom. Load takes priority over shift.
module seq_runner_shift
    import seq_runner_pkg::*;
#(
    parameter int unsigned N = SEQ_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] din,
    output logic         msb
);

    logic [N-1:0] sh_q;
    logic [N-1:0] sh_d;

    // next contents: load, shift or hold
    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = din;
        end else if (shift) begin
            sh_d = {sh_q[N-2:0], 1'b0};
        end else begin
            sh_d = sh_q;
        end
    end

    // storage
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= {N{1'b0}};
        end else begin
            sh_q <= sh_d;
        end
    end

    assign msb = sh_q[N-1];

endmodule

// File: rtl/seq_runner.sv
// Streams a captured N-bit pattern MSB first into an external serial detector
// and records which stream positions made the detector fire.
module seq_runner
    import seq_runner_pkg::*;
#(
    parameter int unsigned N = SEQ_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] seq_in,
    output logic         det_rst,
    output logic         det_x,
    input  logic         det_y,
    output logic         busy,
    output logic         done,
    output logic [6:0]   hit_count,
    output logic [6:0]   first_hit,
    output logic [N-1:0] hit_map
);

    state_t       state_q, state_d;
    logic [6:0]   idx_q, idx_d;
    logic [6:0]   hit_count_q, hit_count_d;
    logic [6:0]   first_hit_q, first_hit_d;
    logic [N-1:0] hit_map_q, hit_map_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         det_rst_q, det_rst_d;
    logic         det_x_q, det_x_d;

    logic         accept_s;
    logic         shift_en_s;
    logic         sh_msb_s;
    logic         sample_s;
    logic [6:0]   sample_idx_s;
    logic [N-1:0] sample_mask_s;

    assign accept_s = (state_q == ST_IDLE) && start;

    seq_runner_shift #(.N(N)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (accept_s),
        .shift (shift_en_s),
        .din   (seq_in),
        .msb   (sh_msb_s)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: state_d = abort ? ST_IDLE : ST_RUN;
            ST_RUN:   state_d = abort ? ST_IDLE :
                                ((idx_q == 7'(N - 1)) ? ST_DRAIN : ST_RUN);
            ST_DRAIN: state_d = abort ? ST_IDLE : ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are flop-driven yet
    // line up with the state they belong to; the bit fed to the detector is
    // the one the shift register advances past on the same edge.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        det_rst_d  = (state_d == ST_CLEAR);
        shift_en_s = (state_d == ST_RUN);
        det_x_d    = (state_d == ST_RUN) ? sh_msb_s : 1'b0;
    end

    // det_y lags det_x by one cycle, so RUN cycle k (k>=1) and DRAIN report index k-1
    always_comb begin
        idx_d         = (state_q == ST_RUN) ? (idx_q + 7'd1) : 7'd0;
        sample_s      = ((state_q == ST_RUN) && (idx_q != 7'd0)) || (state_q == ST_DRAIN);
        sample_idx_s  = idx_q - 7'd1;
        sample_mask_s = {{(N-1){1'b0}}, 1'b1} << sample_idx_s;
    end

    // result accumulation
    always_comb begin
        hit_count_d = hit_count_q;
        first_hit_d = first_hit_q;
        hit_map_d   = hit_map_q;
        if (accept_s) begin
            hit_count_d = 7'd0;
            first_hit_d = NO_HIT;
            hit_map_d   = {N{1'b0}};
        end else if (sample_s && det_y) begin
            hit_count_d = hit_count_q + 7'd1;
            hit_map_d   = hit_map_q | sample_mask_s;
            first_hit_d = (first_hit_q == NO_HIT) ? sample_idx_s : first_hit_q;
        end else begin
            hit_count_d = hit_count_q;
        end
    end

    // datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= 7'd0;
            hit_count_q <= 7'd0;
            first_hit_q <= NO_HIT;
            hit_map_q   <= {N{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            det_rst_q   <= 1'b1;
            det_x_q     <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            hit_count_q <= hit_count_d;
            first_hit_q <= first_hit_d;
            hit_map_q   <= hit_map_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            det_rst_q   <= det_rst_d;
            det_x_q     <= det_x_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign det_rst   = det_rst_q;
    assign det_x     = det_x_q;
    assign hit_count = hit_count_q;
    assign first_hit = first_hit_q;
    assign hit_map   = hit_map_q;

endmodule

// File: tb/tb_seq_runner.sv
// Directed bench for seq_runner with a one-cycle-delay serial detector model.
module tb_seq_runner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] seq_in = 64'd0;
    logic        det_rst;
    logic        det_x;
    logic        det_y = 1'b0;
    logic        busy;
    logic        done;
    logic [6:0]  hit_count;
    logic [6:0]  first_hit;
    logic [63:0] hit_map;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    int nd;
    int extra;

    seq_runner dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .seq_in    (seq_in),
        .det_rst   (det_rst),
        .det_x     (det_x),
        .det_y     (det_y),
        .busy      (busy),
        .done      (done),
        .hit_count (hit_count),
        .first_hit (first_hit),
        .hit_map   (hit_map)
    );

    always #5 clk = ~clk;

    // detector model: det_x delayed one cycle, cleared by det_rst
    always @(posedge clk) begin
        det_y <= det_rst ? 1'b0 : det_x;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"},  64'(busy),      64'd0);
        check_val({tag, "_done"},  64'(done),      64'd0);
        check_val({tag, "_drst"},  64'(det_rst),   64'd1);
        check_val({tag, "_detx"},  64'(det_x),     64'd0);
        check_val({tag, "_hc"},    64'(hit_count), 64'd0);
        check_val({tag, "_fh"},    64'(first_hit), 64'h7F);
        check_val({tag, "_map"},   hit_map,        64'd0);
    endtask

    // Accept a run, then walk cycle by cycle (cycle c = c edges after the
    // accepting cycle) until done or a 100-cycle budget expires.
    task automatic run(input logic [63:0] pat, input bit from_done, input int inj_start,
                       input int abort_at, input int rst_at, output int lat_o, output int nd_o);
        if (from_done) begin
            seq_in = pat;
            start  = 1'b1;
            @(posedge clk); #1;
            check_val("done_start_ignored", 64'(busy), 64'd0);
        end else begin
            @(negedge clk);
            seq_in = pat;
            start  = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check_val("clear_det_rst", 64'(det_rst), 64'd1);
        check_val("clear_busy",    64'(busy),    64'd1);
        lat_o = 0;
        nd_o  = 0;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin
                nd_o++;
                lat_o = c;
                break;
            end
            if (abort_at == 0 && rst_at == 0) begin
                if (c == 2)  check_val("det_x_k0",    64'(det_x), 64'(pat[63]));
                if (c == 65) check_val("det_x_k63",   64'(det_x), 64'(pat[0]));
                if (c == 66) check_val("det_x_drain", 64'(det_x), 64'd0);
            end
            if (c == inj_start) start = 1'b1;
            if (c == abort_at)  abort = 1'b1;
            if (c == rst_at)    rst   = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (c == abort_at) begin
                check_val("abort_busy", 64'(busy),  64'd0);
                check_val("abort_done", 64'(done),  64'd0);
                check_val("abort_detx", 64'(det_x), 64'd0);
            end
            if (c == rst_at) begin
                check_reset_outputs("midrst");
                @(posedge clk); #1;
                check_val("midrst_held_drst", 64'(det_rst), 64'd1);
                rst = 1'b0;
            end
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("idle_det_rst", 64'(det_rst), 64'd0);

        // all-zero pattern
        run(64'h0, 1'b0, 0, 0, 0, lat, nd);
        check_val("zero_lat", 64'(lat),       64'd67);
        check_val("zero_hc",  64'(hit_count), 64'd0);
        check_val("zero_fh",  64'(first_hit), 64'h7F);
        check_val("zero_map", hit_map,        64'd0);
        @(posedge clk); #1;
        check_val("zero_done_low", 64'(done), 64'd0);
        check_val("zero_busy_low", 64'(busy), 64'd0);

        // end bits only
        run(64'h8000_0000_0000_0001, 1'b0, 0, 0, 0, lat, nd);
        check_val("ends_lat", 64'(lat),       64'd67);
        check_val("ends_hc",  64'(hit_count), 64'd2);
        check_val("ends_fh",  64'(first_hit), 64'd0);
        check_val("ends_map", hit_map,        64'h8000_0000_0000_0001);

        // all ones with a stray start during RUN
        repeat (2) @(posedge clk);
        run(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 20, 0, 0, lat, nd);
        check_val("ones_lat", 64'(lat),       64'd67);
        check_val("ones_hc",  64'(hit_count), 64'd64);
        check_val("ones_fh",  64'(first_hit), 64'd0);
        check_val("ones_map", hit_map,        64'hFFFF_FFFF_FFFF_FFFF);
        count_dones(70, extra);
        check_val("ones_single_done", 64'(nd + extra), 64'd1);
        check_val("ones_hold_hc",     64'(hit_count),  64'd64);

        // abort in RUN cycle 10, then a normal run
        run(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 12, 0, lat, nd);
        check_val("abort_no_done", 64'(nd), 64'd0);
        run(64'h0000_0000_0000_00FF, 1'b0, 0, 0, 0, lat, nd);
        check_val("post_abort_lat", 64'(lat),       64'd67);
        check_val("post_abort_hc",  64'(hit_count), 64'd8);
        check_val("post_abort_fh",  64'(first_hit), 64'd56);
        check_val("post_abort_map", hit_map,        64'hFF00_0000_0000_0000);

        // reset in RUN cycle 30
        repeat (2) @(posedge clk);
        run(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 0, 0, 32, lat, nd);
        check_val("midrst_no_done", 64'(nd), 64'd0);

        // back-to-back: second start raised in the DONE cycle, accepted in IDLE
        run(64'hFFFF_0000_0000_0000, 1'b0, 0, 0, 0, lat, nd);
        check_val("b2b1_lat", 64'(lat),       64'd67);
        check_val("b2b1_hc",  64'(hit_count), 64'd16);
        check_val("b2b1_map", hit_map,        64'h0000_0000_0000_FFFF);
        run(64'h0000_0000_0001_0000, 1'b1, 0, 0, 0, lat, nd);
        check_val("b2b2_lat", 64'(lat),       64'd67);
        check_val("b2b2_hc",  64'(hit_count), 64'd1);
        check_val("b2b2_fh",  64'(first_hit), 64'd47);
        check_val("b2b2_map", hit_map,        64'h0000_8000_0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
